pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control unit that drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers. It consumes the hazard flags those registers export (load in ID/EX, register write in ID/EX) and the exception signals carried by ID/EX. From these it generates load-use bubbles, branch flushes, memory-wait freezes and trap redirection. It sits beside the five pipeline registers, between the decode/execute datapath and the CSR file.

## Interface
Parameters:
- PC_W, 32, program-counter width
- GPR_AW, 5, GPR address width
- CNT_W, 32, width of the stall-cycle counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_en  in  1  global run enable; when 0 the FSM holds and all stall outputs are 1
- load_in_id_ex  in  1  load with GPR write is in ID/EX
- id_dst_addr  in  GPR_AW  destination register in ID/EX
- rs1_addr, rs2_addr  in  GPR_AW each  source registers of the instruction in IF/ID
- rs1_used, rs2_used  in  1 each  the IF/ID instruction actually reads rs1 / rs2
- id_pc  in  PC_W  PC in ID/EX
- id_ecall_en, id_ebreak_en  in  1 each  ecall / ebreak in ID/EX
- id_exp_code  in  4  nonzero means an illegal or misaligned exception in ID/EX
- br_taken  in  1  taken branch or jump resolved in EX
- br_target  in  PC_W  branch target
- mem_busy  in  1  data memory has not completed its access
- mtvec  in  PC_W  trap vector base
- dbg_resume  in  1  leave HALT (single-cycle pulse)
- if_stall, id_stall  out  1  hold IF/ID, hold ID/EX
- if_flush, id_flush  out  1  clear IF/ID, clear ID/EX
- redirect_en  out  1  load redirect_pc into the fetch PC
- redirect_pc  out  PC_W  new fetch PC
- mepc_we  out  1  write mepc/mcause this cycle
- mepc_wdata  out  PC_W  faulting PC
- mcause_wdata  out  4  3 = ebreak, 11 = ecall, otherwise id_exp_code
- halted  out  1  FSM is in HALT
- stall_cycles  out  CNT_W  saturating count of cycles with if_stall=1

## Operation
- States: RUN, MEM_WAIT, TRAP, HALT. Reset state is RUN.
- Hazard definitions:
  - load_use = load_in_id_ex & id_dst_addr≠0 & ((rs1_used & rs1_addr==id_dst_addr) | (rs2_used & rs2_addr==id_dst_addr)).
  - trap_req = id_ecall_en | id_exp_code≠0 | (id_ebreak_en without EBREAK_HALT_EN).
- RUN priority order, highest first:
  1. trap_req: assert if_flush and id_flush, mepc_we=1, mepc_wdata=id_pc; go to TRAP.
  2. br_taken: assert if_flush, id_flush, redirect_en, with redirect_pc=br_target; stay in RUN.
  3. mem_busy: assert if_stall and id_stall; go to MEM_WAIT.
  4. load_use: assert if_stall and id_flush (one bubble); stay in RUN.
- MEM_WAIT: if_stall=id_stall=1 while mem_busy=1. Return to RUN in the first cycle mem_busy=0; stalls drop in that same cycle.
- TRAP: lasts one cycle. redirect_en=1, redirect_pc={mtvec[PC_W-1:2],2'b00}, if_flush=id_flush=1. Next state is RUN.
- HALT: if_stall=id_stall=1. Exit to RUN on the cycle after dbg_resume=1.
- stall_cycles increments on every clock with if_stall=1 and saturates at all-ones.

## Timing
- Reset values: all outputs 0, stall_cycles 0, state RUN.
- Stall, flush and mepc outputs are combinational from the current state and inputs, so they take effect at the same clock edge the pipeline registers sample.
- A trap redirects exactly one cycle after detection.
- A branch redirects in the same cycle it is resolved.
- Simultaneous events:
  - trap_req with br_taken: trap wins and the branch is discarded.
  - mem_busy with load_use: MEM_WAIT wins; load_use is re-evaluated after the wait.
- cpu_en=0: state and counter frozen, if_stall=id_stall=1, flushes and redirect forced to 0.
- rst_n asserted mid-TRAP or mid-HALT: return to RUN immediately with no redirect issued.

## Configuration
- EBREAK_HALT_EN defined: id_ebreak_en in RUN asserts id_flush and enters HALT. The instruction does not retire and mepc is not written.
- EBREAK_HALT_EN undefined: ebreak is a normal trap with mcause 3, and the HALT state is unreachable (halted stays 0).

## Test plan
- Load-use: load x5 in ID/EX, IF/ID reads rs1=x5 with rs1_used=1 -> one cycle of if_stall=1 and id_flush=1; stall_cycles=1. Repeat with dst=x0 -> no stall.
- Branch: br_taken=1, br_target=0x100 -> redirect_en=1, redirect_pc=0x100, if_flush=id_flush=1 for one cycle.
- Ecall at id_pc=0x80, mtvec=0x203 -> mepc_we=1, mepc_wdata=0x80, mcause_wdata=11; next cycle redirect_pc=0x200.
- mem_busy high for 3 cycles -> if_stall=id_stall=1 for exactly 3 cycles; stall_cycles advances by 3.
- Ecall together with br_taken -> only the trap sequence; redirect_pc is never 0x100.
- Ebreak with EBREAK_HALT_EN defined -> halted=1 until one cycle after a dbg_resume pulse. Ebreak without the macro -> mcause_wdata=3 and a trap redirect.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/trap sequencing for the IF/ID and ID/EX pipeline registers.
// Optional build macro: EBREAK_HALT_EN (ebreak enters a debug HALT instead of trapping).
//
// state    | meaning
// RUN      | normal issue, hazards resolved every cycle
// MEM_WAIT | pipeline frozen until the data memory completes
// TRAP     | one-cycle redirect of fetch to the aligned trap vector
// HALT     | debug halt, held until a dbg_resume pulse
module pipe_hazard_ctrl #(
  parameter int PC_W   = 32,
  parameter int GPR_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic              load_in_id_ex,
  input  logic [GPR_AW-1:0] id_dst_addr,
  input  logic [GPR_AW-1:0] rs1_addr,
  input  logic [GPR_AW-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_ecall_en,
  input  logic              id_ebreak_en,
  input  logic [3:0]        id_exp_code,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              mem_busy,
  input  logic [PC_W-1:0]   mtvec,
  input  logic              dbg_resume,
  output logic              if_stall,
  output logic              id_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              redirect_en,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              mepc_we,
  output logic [PC_W-1:0]   mepc_wdata,
  output logic [3:0]        mcause_wdata,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP, HALT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic ebreak_trap;
  logic ebreak_halt;
  logic trap_req;
  logic run_eval;
  logic [3:0] cause;

  assign load_use = load_in_id_ex && (id_dst_addr != '0) &&
                    ((rs1_used && (rs1_addr == id_dst_addr)) ||
                     (rs2_used && (rs2_addr == id_dst_addr)));

`ifdef EBREAK_HALT_EN
  assign ebreak_trap = 1'b0;
  assign ebreak_halt = id_ebreak_en;
`else
  assign ebreak_trap = id_ebreak_en;
  assign ebreak_halt = 1'b0;
`endif

  assign trap_req = id_ecall_en || (id_exp_code != 4'd0) || ebreak_trap;
  assign cause    = ebreak_trap ? 4'd3 : (id_ecall_en ? 4'd11 : id_exp_code);

  always_comb begin
    state_d      = state_q;
    if_stall     = 1'b0;
    id_stall     = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = '0;
    mepc_we      = 1'b0;
    mepc_wdata   = '0;
    mcause_wdata = 4'd0;
    run_eval     = 1'b0;

    if (!cpu_en) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
    end else begin
      case (state_q)
        RUN: run_eval = 1'b1;
        MEM_WAIT: begin
          // Release cycle behaves like RUN so a hazard present then is not lost.
          if (mem_busy) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
          end else begin
            state_d  = RUN;
            run_eval = 1'b1;
          end
        end
        TRAP: begin
          redirect_en = 1'b1;
          redirect_pc = {mtvec[PC_W-1:2], 2'b00};
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          state_d     = RUN;
        end
        HALT: begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          if (dbg_resume) state_d = RUN;
        end
        default: state_d = RUN;
      endcase

      if (run_eval) begin
        if (trap_req) begin
          if_flush     = 1'b1;
          id_flush     = 1'b1;
          mepc_we      = 1'b1;
          mepc_wdata   = id_pc;
          mcause_wdata = cause;
          state_d      = TRAP;
        end else if (ebreak_halt) begin
          id_flush = 1'b1;
          state_d  = HALT;
        end else if (br_taken) begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          redirect_en = 1'b1;
          redirect_pc = br_target;
        end else if (mem_busy) begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          state_d  = MEM_WAIT;
        end else if (load_use) begin
          if_stall = 1'b1;
          id_flush = 1'b1;
        end
      end
    end
  end

  assign halted = (state_q == HALT);

  // Counter is frozen with cpu_en low even though the stalls are forced high.
  assign stall_cycles_d = (cpu_en && if_stall && (stall_cycles_q != '1)) ?
                          stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  assign stall_cycles   = stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else if (cpu_en) begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases from the hazard rules, then random traffic
// checked against an event-level reference model. Honours EBREAK_HALT_EN like the design.
module tb_pipe_hazard_ctrl;
  localparam int PW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef EBREAK_HALT_EN
  localparam bit HALT_BUILD = 1'b1;
`else
  localparam bit HALT_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic          rst_n, cpu_en, load, rs1u, rs2u, ecall, ebreak, br, mem_busy, resume;
    logic [AW-1:0] dst, rs1, rs2;
    logic [3:0]    exp_code;
    logic [PW-1:0] id_pc, target, mtvec;
  } stim_t;

  typedef struct packed {
    logic          if_stall, id_stall, if_flush, id_flush, redirect_en, mepc_we, halted;
    logic [PW-1:0] redirect_pc, mepc_wdata;
    logic [3:0]    mcause;
    logic [CW-1:0] cnt;
    logic [31:0]   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, cpu_en, load_in_id_ex, rs1_used, rs2_used, id_ecall_en, id_ebreak_en;
  logic br_taken, mem_busy, dbg_resume;
  logic [AW-1:0] id_dst_addr, rs1_addr, rs2_addr;
  logic [3:0]    id_exp_code;
  logic [PW-1:0] id_pc, br_target, mtvec;
  logic if_stall, id_stall, if_flush, id_flush, redirect_en, mepc_we, halted;
  logic [PW-1:0] redirect_pc, mepc_wdata;
  logic [3:0]    mcause_wdata;
  logic [CW-1:0] stall_cycles;

  pipe_hazard_ctrl #(.PC_W(PW), .GPR_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .load_in_id_ex(load_in_id_ex),
    .id_dst_addr(id_dst_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .id_pc(id_pc),
    .id_ecall_en(id_ecall_en), .id_ebreak_en(id_ebreak_en), .id_exp_code(id_exp_code),
    .br_taken(br_taken), .br_target(br_target), .mem_busy(mem_busy), .mtvec(mtvec),
    .dbg_resume(dbg_resume), .if_stall(if_stall), .id_stall(id_stall),
    .if_flush(if_flush), .id_flush(id_flush), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
    .mcause_wdata(mcause_wdata), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  exp_t sb_q[$];

  // Reference model: what is pending from earlier cycles, tracked as plain flags.
  bit          m_redirect_due;
  bit          m_waiting_mem;
  bit          m_in_halt;
  int unsigned m_cnt;

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit   lu, ebk_trap;
    e = '0;
    e.cyc = cyc_n;
    if (!s.rst_n) begin
      m_redirect_due = 0; m_waiting_mem = 0; m_in_halt = 0; m_cnt = 0;
      return e;
    end
    e.halted = m_in_halt;
    e.cnt    = m_cnt[CW-1:0];
    if (!s.cpu_en) begin
      e.if_stall = 1; e.id_stall = 1;
      return e;
    end
    if (m_redirect_due) begin
      e.redirect_en = 1; e.redirect_pc = s.mtvec & ~32'h3;
      e.if_flush = 1; e.id_flush = 1;
      m_redirect_due = 0;
    end else if (m_in_halt) begin
      e.if_stall = 1; e.id_stall = 1;
      if (s.resume) m_in_halt = 0;
    end else if (m_waiting_mem && s.mem_busy) begin
      e.if_stall = 1; e.id_stall = 1;
    end else begin
      m_waiting_mem = 0;
      lu = s.load && s.dst != 0 && ((s.rs1u && s.rs1 == s.dst) || (s.rs2u && s.rs2 == s.dst));
      ebk_trap = s.ebreak && !HALT_BUILD;
      if (s.ecall || s.exp_code != 0 || ebk_trap) begin
        e.if_flush = 1; e.id_flush = 1; e.mepc_we = 1; e.mepc_wdata = s.id_pc;
        e.mcause = ebk_trap ? 4'd3 : (s.ecall ? 4'd11 : s.exp_code);
        m_redirect_due = 1;
      end else if (s.ebreak) begin
        e.id_flush = 1;
        m_in_halt = 1;
      end else if (s.br) begin
        e.if_flush = 1; e.id_flush = 1; e.redirect_en = 1; e.redirect_pc = s.target;
      end else if (s.mem_busy) begin
        e.if_stall = 1; e.id_stall = 1;
        m_waiting_mem = 1;
      end else if (lu) begin
        e.if_stall = 1; e.id_flush = 1;
      end
    end
    if (e.if_stall) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1; s.cpu_en = 1;
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rst_n; cpu_en = s.cpu_en; load_in_id_ex = s.load;
    id_dst_addr = s.dst; rs1_addr = s.rs1; rs2_addr = s.rs2;
    rs1_used = s.rs1u; rs2_used = s.rs2u; id_pc = s.id_pc;
    id_ecall_en = s.ecall; id_ebreak_en = s.ebreak; id_exp_code = s.exp_code;
    br_taken = s.br; br_target = s.target; mem_busy = s.mem_busy;
    mtvec = s.mtvec; dbg_resume = s.resume;
    sb_q.push_back(model(s));
    cyc_n++;
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("if_stall",     e.cyc, if_stall,     e.if_stall);
        chk("id_stall",     e.cyc, id_stall,     e.id_stall);
        chk("if_flush",     e.cyc, if_flush,     e.if_flush);
        chk("id_flush",     e.cyc, id_flush,     e.id_flush);
        chk("redirect_en",  e.cyc, redirect_en,  e.redirect_en);
        chk("redirect_pc",  e.cyc, redirect_pc,  e.redirect_pc);
        chk("mepc_we",      e.cyc, mepc_we,      e.mepc_we);
        chk("mepc_wdata",   e.cyc, mepc_wdata,   e.mepc_wdata);
        chk("mcause_wdata", e.cyc, mcause_wdata, e.mcause);
        chk("halted",       e.cyc, halted,       e.halted);
        chk("stall_cycles", e.cyc, stall_cycles, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    stim_t s;
    rst_n = 0; cpu_en = 1; load_in_id_ex = 0; id_dst_addr = 0; rs1_addr = 0; rs2_addr = 0;
    rs1_used = 0; rs2_used = 0; id_pc = 0; id_ecall_en = 0; id_ebreak_en = 0;
    id_exp_code = 0; br_taken = 0; br_target = 0; mem_busy = 0; mtvec = 0; dbg_resume = 0;

    s = idle(); s.rst_n = 0;
    repeat (2) cycle(s);
    cycle(idle());

    // Load-use on rs1, then with x0 destination, then an unused rs2 match.
    s = idle(); s.load = 1; s.dst = 5; s.rs1 = 5; s.rs1u = 1;
    cycle(s); cycle(idle());
    s.dst = 0; s.rs1 = 0; cycle(s);
    s = idle(); s.load = 1; s.dst = 7; s.rs2 = 7; s.rs2u = 0; cycle(s);
    s.rs2u = 1; cycle(s); cycle(idle());

    s = idle(); s.br = 1; s.target = 32'h100;
    cycle(s); cycle(idle());

    s = idle(); s.ecall = 1; s.id_pc = 32'h80; s.mtvec = 32'h203;
    cycle(s);
    s = idle(); s.mtvec = 32'h203; cycle(s); cycle(idle());

    s = idle(); s.mem_busy = 1;
    repeat (3) cycle(s);
    cycle(idle()); cycle(idle());

    s = idle(); s.ecall = 1; s.br = 1; s.target = 32'h100; s.id_pc = 32'h44; s.mtvec = 32'h1000;
    cycle(s);
    s = idle(); s.br = 1; s.target = 32'h100; s.mtvec = 32'h1000; cycle(s); cycle(idle());

    s = idle(); s.ebreak = 1; s.id_pc = 32'h90; s.mtvec = 32'h400;
    cycle(s);
    s = idle(); s.mtvec = 32'h400;
    repeat (3) cycle(s);
    s.resume = 1; cycle(s);
    s.resume = 0; cycle(s); cycle(s);

    // Reset landing in the TRAP cycle must suppress the redirect.
    s = idle(); s.exp_code = 4'd4; s.id_pc = 32'h120; s.mtvec = 32'h800;
    cycle(s);
    s = idle(); s.rst_n = 0; cycle(s);
    cycle(idle());

    s = idle(); s.cpu_en = 0; s.br = 1; s.target = 32'h100; s.mem_busy = 1;
    repeat (2) cycle(s);
    cycle(idle());

    s = idle(); s.mem_busy = 1; s.load = 1; s.dst = 3; s.rs1 = 3; s.rs1u = 1;
    repeat (2) cycle(s);
    s.mem_busy = 0; cycle(s); cycle(idle());

    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst_n    = ($urandom_range(0, 199) != 0);
      s.cpu_en   = ($urandom_range(0, 9) != 0);
      s.load     = $urandom_range(0, 1);
      s.dst      = AW'($urandom_range(0, 3));
      s.rs1      = AW'($urandom_range(0, 3));
      s.rs2      = AW'($urandom_range(0, 3));
      s.rs1u     = $urandom_range(0, 1);
      s.rs2u     = $urandom_range(0, 1);
      s.id_pc    = $urandom;
      s.ecall    = ($urandom_range(0, 19) == 0);
      s.ebreak   = ($urandom_range(0, 19) == 0);
      s.exp_code = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      s.br       = ($urandom_range(0, 4) == 0);
      s.target   = $urandom;
      s.mem_busy = ($urandom_range(0, 2) == 0);
      s.mtvec    = $urandom;
      s.resume   = ($urandom_range(0, 3) == 0);
      if (!s.rst_n) begin
        s = idle(); s.rst_n = 0;
      end
      cycle(s);
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", cyc_n, sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
